// File: rtl/ctrl_decode_pipe.sv
// Registered instruction-decode/control stage with valid/ready handshake and mul/div sequencing.
// Optional macro CTRL_ILLEGAL_TRAP_EN: an accepted illegal encoding parks the stage in TRAP until reset.
module ctrl_decode_pipe #(
  parameter int unsigned INSN_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              DMwe,
  output logic              Rwe,
  output logic              Rwd,
  output logic              ALUinB,
  output logic [4:0]        ALUop,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [4:0]        shamt,
  output logic [DATA_W-1:0] imm,
  output logic              md_start,
  output logic              md_sel,
  output logic              illegal
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned FLD_W  = 5;
  localparam int unsigned IMM_W  = 17;

  localparam logic [FLD_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [FLD_W-1:0] OP_ADDI  = 5'b00101;
  localparam logic [FLD_W-1:0] OP_SW    = 5'b00111;
  localparam logic [FLD_W-1:0] OP_LW    = 5'b01000;
  localparam logic [FLD_W-1:0] FN_MUL   = 5'b00110;
  localparam logic [FLD_W-1:0] FN_DIV   = 5'b00111;
  localparam logic [FLD_W-1:0] FN_LAST  = 5'b00101;

`ifdef CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MD_WAIT = 2'd1, S_TRAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MD_WAIT = 2'd1} state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              dm_we_q, dm_we_d;
  logic              r_we_q, r_we_d;
  logic              r_wd_q, r_wd_d;
  logic              alu_in_b_q, alu_in_b_d;
  logic [4:0]        alu_op_q, alu_op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              md_start_q, md_start_d;
  logic              md_sel_q, md_sel_d;
  logic              illegal_q, illegal_d;

  logic [FLD_W-1:0]  f_op, f_func;
  logic              dec_dm_we, dec_r_we, dec_r_wd, dec_alu_in_b, dec_illegal, dec_md;
  logic [4:0]        dec_alu_op;
  logic              ready_c, accept_c, handshake_c;
  logic              unused_insn_bits;

  assign f_op             = insn[31:27];
  assign f_func           = insn[6:2];
  assign unused_insn_bits = ^insn[1:0];

  // Opcode/func decode; anything not recognised becomes a flagged NOP.
  always_comb begin
    dec_dm_we    = 1'b0;
    dec_r_we     = 1'b0;
    dec_r_wd     = 1'b0;
    dec_alu_in_b = 1'b0;
    dec_alu_op   = 5'd0;
    dec_illegal  = 1'b0;
    dec_md       = 1'b0;
    case (f_op)
      OP_RTYPE: begin
        if (f_func <= FN_LAST) begin
          dec_r_we   = 1'b1;
          dec_alu_op = f_func;
        end else if ((f_func == FN_MUL) || (f_func == FN_DIV)) begin
          dec_md     = 1'b1;
          dec_r_we   = 1'b1;
          dec_alu_op = f_func;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_ADDI: begin
        dec_r_we     = 1'b1;
        dec_alu_in_b = 1'b1;
      end
      OP_SW: begin
        dec_dm_we    = 1'b1;
        dec_alu_in_b = 1'b1;
      end
      OP_LW: begin
        dec_r_we     = 1'b1;
        dec_r_wd     = 1'b1;
        dec_alu_in_b = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Reset gates ready so the stage never advertises intake while held in reset.
  assign ready_c     = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept_c    = in_valid && ready_c;
  assign handshake_c = out_valid_q && out_ready;

  // Next-state and output-word logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    dm_we_d     = dm_we_q;
    r_we_d      = r_we_q;
    r_wd_d      = r_wd_q;
    alu_in_b_d  = alu_in_b_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    shamt_d     = shamt_q;
    imm_d       = imm_q;
    md_start_d  = 1'b0;
    md_sel_d    = md_sel_q;
    illegal_d   = illegal_q;

    if (handshake_c) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          rd_d       = REG_AW'(insn[26:22]);
          rs_d       = REG_AW'(insn[21:17]);
          rt_d       = REG_AW'(insn[16:12]);
          shamt_d    = insn[11:7];
          imm_d      = {{(DATA_W-IMM_W){insn[16]}}, insn[16:0]};
          dm_we_d    = dec_dm_we;
          r_we_d     = dec_r_we;
          r_wd_d     = dec_r_wd;
          alu_in_b_d = dec_alu_in_b;
          alu_op_d   = dec_alu_op;
          illegal_d  = dec_illegal;
          if (dec_md) begin
            // The word is parked in the output register, invisible until the wait ends.
            md_start_d = 1'b1;
            md_sel_d   = f_func[0];
            cnt_d      = CNT_W'(MD_LATENCY - 1);
            state_d    = S_MD_WAIT;
          end else begin
            out_valid_d = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (dec_illegal) begin
              state_d = S_TRAP;
            end
`endif
          end
        end
      end
      S_MD_WAIT: begin
        if (cnt_q == '0) begin
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        state_d = S_TRAP;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      dm_we_q     <= 1'b0;
      r_we_q      <= 1'b0;
      r_wd_q      <= 1'b0;
      alu_in_b_q  <= 1'b0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      shamt_q     <= '0;
      imm_q       <= '0;
      md_start_q  <= 1'b0;
      md_sel_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      dm_we_q     <= dm_we_d;
      r_we_q      <= r_we_d;
      r_wd_q      <= r_wd_d;
      alu_in_b_q  <= alu_in_b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      shamt_q     <= shamt_d;
      imm_q       <= imm_d;
      md_start_q  <= md_start_d;
      md_sel_q    <= md_sel_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready  = ready_c;
  assign out_valid = out_valid_q;
  assign DMwe      = dm_we_q;
  assign Rwe       = r_we_q;
  assign Rwd       = r_wd_q;
  assign ALUinB    = alu_in_b_q;
  assign ALUop     = alu_op_q;
  assign rd        = rd_q;
  assign rs        = rs_q;
  assign rt        = rt_q;
  assign shamt     = shamt_q;
  assign imm       = imm_q;
  assign md_start  = md_start_q;
  assign md_sel    = md_sel_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe: directed steps followed by a randomized run against a reference model.
module tb_ctrl_decode_pipe;

  localparam int unsigned LAT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] insn;
  logic        out_valid;
  logic        out_ready;
  logic        DMwe, Rwe, Rwd, ALUinB;
  logic [4:0]  ALUop;
  logic [4:0]  rd, rs, rt, shamt;
  logic [31:0] imm;
  logic        md_start, md_sel, illegal;

  ctrl_decode_pipe #(
    .INSN_W(32), .DATA_W(32), .REG_AW(5), .MD_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .insn(insn),
    .out_valid(out_valid), .out_ready(out_ready),
    .DMwe(DMwe), .Rwe(Rwe), .Rwd(Rwd), .ALUinB(ALUinB), .ALUop(ALUop),
    .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .imm(imm),
    .md_start(md_start), .md_sel(md_sel), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        dm_we;
    logic        r_we;
    logic        r_wd;
    logic        alu_b;
    logic [4:0]  alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        illegal;
  } word_t;

  word_t obs_w;
  assign obs_w = {DMwe, Rwe, Rwd, ALUinB, ALUop, rd, rs, rt, shamt, imm, illegal};

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mk_r(input logic [4:0] d, input logic [4:0] s,
                                       input logic [4:0] t, input logic [4:0] sh,
                                       input logic [4:0] fn);
    return {5'd0, d, s, t, sh, fn, 2'b00};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] d,
                                       input logic [4:0] s, input logic [16:0] im);
    return {op, d, s, im};
  endfunction

  function automatic bit is_md(input logic [31:0] i);
    return (i[31:27] == 5'd0) && ((i[6:2] == 5'd6) || (i[6:2] == 5'd7));
  endfunction

  // Expected control word straight from the decode table.
  function automatic word_t ref_dec(input logic [31:0] i);
    word_t w;
    logic [4:0] op;
    logic [4:0] fn;
    op = i[31:27];
    fn = i[6:2];
    w = '0;
    w.rd = i[26:22];
    w.rs = i[21:17];
    w.rt = i[16:12];
    w.shamt = i[11:7];
    w.imm = {{15{i[16]}}, i[16:0]};
    if (op == 5'd0 && fn <= 5'd7) begin
      w.r_we = 1'b1;
      w.alu_op = fn;
    end else if (op == 5'd5) begin
      w.r_we = 1'b1;
      w.alu_b = 1'b1;
    end else if (op == 5'd7) begin
      w.dm_we = 1'b1;
      w.alu_b = 1'b1;
    end else if (op == 5'd8) begin
      w.r_we = 1'b1;
      w.r_wd = 1'b1;
      w.alu_b = 1'b1;
    end else begin
      w.illegal = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3: return {5'd0, r[26:7], 5'($urandom_range(0, 5)), r[1:0]};
      4: return {5'd5, r[26:0]};
      5: return {5'd7, r[26:0]};
      6: return {5'd8, r[26:0]};
      7: return {5'd0, r[26:7], 5'd6, r[1:0]};
      8: return {5'd0, r[26:7], 5'd7, r[1:0]};
`ifdef CTRL_ILLEGAL_TRAP_EN
      default: return {5'd5, r[26:0]};
`else
      default: begin
        if (r[0]) return {5'($urandom_range(9, 31)), r[26:0]};
        else return {5'd0, r[26:7], 5'($urandom_range(8, 31)), r[1:0]};
      end
`endif
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] cur, held_next;
  bit          mv, exp_rdy, acc, exp_ms, exp_sel, iv, ordy;
  word_t       mw, pend;
  int          busy;

  initial begin
    // Reset with intake requested: everything must read zero.
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; insn = 32'h00C22000;
    tick(); tick();
    chk("reset_word", 64'(obs_w), 64'(0));
    chk("reset_ctl", 64'({out_valid, in_ready, md_start, md_sel}), 64'(0));
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 64'(in_ready), 64'(1));

    // add r3,r1,r2
    tick();
    chk("add_valid", 64'(out_valid), 64'(1));
    chk("add_fields", 64'({Rwe, ALUop, rd, rs, rt, ALUinB}), 64'({1'b1, 5'd0, 5'd3, 5'd1, 5'd2, 1'b0}));
    chk("add_word", 64'(obs_w), 64'(ref_dec(32'h00C22000)));

    insn = 32'h2901FFFF;
    tick();
    chk("addi_imm", 64'(imm), 64'(32'hFFFFFFFF));
    chk("addi_fields", 64'({ALUinB, Rwe, rd}), 64'({1'b1, 1'b1, 5'd4}));

    insn = mk_i(5'd8, 5'd6, 5'd1, 17'h00010);
    tick();
    chk("lw_rwd", 64'(Rwd), 64'(1));
    chk("lw_word", 64'(obs_w), 64'(ref_dec(insn)));

    insn = mk_i(5'd7, 5'd0, 5'd2, 17'h1FFF0);
    tick();
    chk("sw_en", 64'({DMwe, Rwe}), 64'({1'b1, 1'b0}));
    chk("sw_imm", 64'(imm), 64'(32'hFFFFFFF0));

    // Four back-to-back single-cycle words.
    for (int k = 0; k < 4; k++) begin
      cur = mk_r(5'(k + 1), 5'(k), 5'(k + 2), 5'(k), 5'(k));
      insn = cur;
      tick();
      chk("b2b_valid", 64'(out_valid), 64'(1));
      chk("b2b_word", 64'(obs_w), 64'(ref_dec(cur)));
    end

    // Backpressure: word held, no intake.
    held_next = mk_r(5'd9, 5'd9, 5'd9, 5'd0, 5'd1);
    insn = held_next;
    out_ready = 1'b0;
    #1;
    chk("bp_ready_drop", 64'(in_ready), 64'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_hold", 64'(obs_w), 64'(ref_dec(cur)));
      chk("bp_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_back", 64'(in_ready), 64'(1));
    tick();
    chk("bp_replace", 64'(obs_w), 64'(ref_dec(held_next)));
    in_valid = 1'b0;
    tick();
    chk("drain_empty", 64'(out_valid), 64'(0));

    // mul r5,r1,r2 with LAT=4.
    insn = 32'h01422018;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mul_start", 64'({md_start, md_sel, in_ready, out_valid}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("mul_wait", 64'({md_start, in_ready, out_valid}), 64'(0));
    end
    tick();
    chk("mul_done", 64'({out_valid, Rwe, rd, ALUop}), 64'({1'b1, 1'b1, 5'd5, 5'd6}));
    chk("mul_word", 64'(obs_w), 64'(ref_dec(32'h01422018)));
    chk("mul_ready", 64'(in_ready), 64'(1));
    tick();

    // Reset two cycles into a div wait.
    insn = mk_r(5'd7, 5'd1, 5'd2, 5'd0, 5'd7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("div_sel", 64'(md_sel), 64'(1));
    tick();
    reset = 1'b1;
    #1;
    chk("abort_ctl", 64'({out_valid, in_ready, md_start, md_sel}), 64'(0));
    tick();
    reset = 1'b0;
    #1;
    chk("abort_idle", 64'(in_ready), 64'(1));
    cur = mk_r(5'd8, 5'd3, 5'd4, 5'd2, 5'd4);
    insn = cur;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_abort_word", 64'(obs_w), 64'(ref_dec(cur)));
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      chk("no_ghost_div", 64'(out_valid), 64'(0));
    end

    // Illegal encoding.
    insn = {5'b11111, 27'h0ABCDEF};
    in_valid = 1'b1;
    tick();
    chk("ill_flag", 64'({out_valid, illegal}), 64'({1'b1, 1'b1}));
    chk("ill_en", 64'({DMwe, Rwe, Rwd, ALUinB}), 64'(0));
    chk("ill_word", 64'(obs_w), 64'(ref_dec({5'b11111, 27'h0ABCDEF})));
    cur = mk_r(5'd10, 5'd11, 5'd12, 5'd0, 5'd1);
    insn = cur;
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("trap_ready", 64'(in_ready), 64'(0));
      tick();
    end
`else
    #1;
    chk("ill_ready", 64'(in_ready), 64'(1));
    tick();
    chk("ill_next_word", 64'(obs_w), 64'(ref_dec(cur)));
`endif
    in_valid = 1'b0;

    // Randomized run against the reference model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mv = 1'b0; busy = 0; exp_ms = 1'b0; exp_sel = 1'b0; mw = '0; pend = '0;
    for (int n = 0; n < 400; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      cur  = rand_insn();
      in_valid  = iv;
      out_ready = ordy;
      insn      = cur;
      #1;
      exp_rdy = (busy == 0) && (!mv || ordy);
      chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
      acc = iv && exp_rdy;
      @(posedge clock);
      #1;
      exp_ms = 1'b0;
      if (mv && ordy) mv = 1'b0;
      if (acc) begin
        if (is_md(cur)) begin
          busy = LAT;
          pend = ref_dec(cur);
          exp_ms = 1'b1;
          exp_sel = cur[2];
        end else begin
          mw = ref_dec(cur);
          mv = 1'b1;
        end
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          mw = pend;
          mv = 1'b1;
        end
      end
      chk("rnd_out_valid", 64'(out_valid), 64'(mv));
      chk("rnd_md", 64'({md_start, md_sel}), 64'({exp_ms, exp_sel}));
      if (mv) chk("rnd_word", 64'(obs_w), 64'(mw));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
